// File: rtl/axi_sram_pkg.sv
// Shared types and constants for the AXI4-to-SRAM responder.
// Holds the FSM state encoding, the AXI response codes and the strobe-to-bit-mask helper.
package axi_sram_pkg;

  localparam int ID_WIDTH_DEF   = 8;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int LEN_WIDTH_DEF  = 4;
  localparam int SRAM_AW_DEF    = 14;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    R_REQ,
    R_WAIT,
    R_DATA,
    W_DATA,
    B_RESP
  } state_t;

  // SRAM bit enables are active-low: a set strobe bit opens its whole byte lane.
  function automatic logic [31:0] strb_to_bweb(input logic [3:0] strb);
    logic [31:0] bweb;
    for (int k = 0; k < 4; k++) begin
      bweb[8*k +: 8] = strb[k] ? 8'h00 : 8'hFF;
    end
    return bweb;
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI4 slave-side bus bundle between the bridge and one SRAM responder.
// The master modport is the bridge view; the slave modport is the memory view.
interface axi_sram_slave_if
  import axi_sram_pkg::*;
#(
  parameter int ID_WIDTH   = ID_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
);

  logic [ID_WIDTH-1:0]       AWID_S;
  logic [ADDR_WIDTH-1:0]     AWADDR_S;
  logic [LEN_WIDTH-1:0]      AWLEN_S;
  logic [2:0]                AWSIZE_S;
  logic [1:0]                AWBURST_S;
  logic                      AWVALID_S;
  logic                      AWREADY_S;

  logic [DATA_WIDTH-1:0]     WDATA_S;
  logic [DATA_WIDTH/8-1:0]   WSTRB_S;
  logic                      WLAST_S;
  logic                      WVALID_S;
  logic                      WREADY_S;

  logic [ID_WIDTH-1:0]       BID_S;
  logic [1:0]                BRESP_S;
  logic                      BVALID_S;
  logic                      BREADY_S;

  logic [ID_WIDTH-1:0]       ARID_S;
  logic [ADDR_WIDTH-1:0]     ARADDR_S;
  logic [LEN_WIDTH-1:0]      ARLEN_S;
  logic [2:0]                ARSIZE_S;
  logic [1:0]                ARBURST_S;
  logic                      ARVALID_S;
  logic                      ARREADY_S;

  logic [ID_WIDTH-1:0]       RID_S;
  logic [DATA_WIDTH-1:0]     RDATA_S;
  logic [1:0]                RRESP_S;
  logic                      RLAST_S;
  logic                      RVALID_S;
  logic                      RREADY_S;

  modport master (
    output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    input  AWREADY_S,
    output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
    input  WREADY_S,
    input  BID_S, BRESP_S, BVALID_S,
    output BREADY_S,
    output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    input  ARREADY_S,
    input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    output RREADY_S
  );

  modport slave (
    input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    output AWREADY_S,
    input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
    output WREADY_S,
    output BID_S, BRESP_S, BVALID_S,
    input  BREADY_S,
    input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    output ARREADY_S,
    output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    input  RREADY_S
  );

endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 responder that turns one read or write burst at a time into accesses
// on a single-port synchronous SRAM macro; reads win over writes in IDLE.
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int ID_WIDTH   = ID_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int SRAM_AW    = SRAM_AW_DEF
) (
  input  logic                  ACLK,
  input  logic                  rst,
  axi_sram_slave_if.slave       axi,
  output logic                  CEB,
  output logic                  WEB,
  output logic [DATA_WIDTH-1:0] BWEB,
  output logic [SRAM_AW-1:0]    A,
  output logic [DATA_WIDTH-1:0] DI,
  input  logic [DATA_WIDTH-1:0] DO
);

  state_t                state_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [SRAM_AW-1:0]    addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            bresp_q;

  logic last_beat;
  logic w_beat;
  logic w_err;
  logic r_valid;

  assign last_beat = (cnt_q == len_q);
  assign w_err     = (axi.WLAST_S != last_beat);

  // Handshake outputs are masked while rst is high so the bus sees a quiet
  // slave during the reset cycle itself, not only after the reset edge.
  assign w_beat        = !rst && (state_q == W_DATA) && axi.WVALID_S;
  assign r_valid       = !rst && (state_q == R_DATA);

  assign axi.ARREADY_S = !rst && (state_q == IDLE);
  assign axi.AWREADY_S = !rst && (state_q == IDLE) && !axi.ARVALID_S;
  assign axi.WREADY_S  = !rst && (state_q == W_DATA);
  assign axi.BVALID_S  = !rst && (state_q == B_RESP);
  assign axi.BID_S     = id_q;
  assign axi.BRESP_S   = bresp_q;

  assign axi.RVALID_S  = r_valid;
  assign axi.RDATA_S   = rdata_q;
  assign axi.RID_S     = id_q;
  assign axi.RRESP_S   = RESP_OKAY;
  assign axi.RLAST_S   = r_valid && last_beat;

  assign CEB  = !((!rst && (state_q == R_REQ)) || w_beat);
  assign WEB  = !w_beat;
  assign BWEB = w_beat ? strb_to_bweb(axi.WSTRB_S) : '1;
  assign A    = addr_q;
  assign DI   = axi.WDATA_S;

  // Size, burst type and the byte/upper address bits carry no meaning here.
  logic unused_fields;
  assign unused_fields = ^{axi.AWSIZE_S, axi.AWBURST_S, axi.ARSIZE_S, axi.ARBURST_S,
                           axi.AWADDR_S[ADDR_WIDTH-1:SRAM_AW+2], axi.AWADDR_S[1:0],
                           axi.ARADDR_S[ADDR_WIDTH-1:SRAM_AW+2], axi.ARADDR_S[1:0]};

  // NOTE: every register in this block uses <= so all of them update from the
  // same pre-edge values; a blocking = here would let later lines see new state.
  always_ff @(posedge ACLK) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          if (axi.ARVALID_S) begin
            id_q    <= axi.ARID_S;
            addr_q  <= axi.ARADDR_S[SRAM_AW+1:2];
            len_q   <= axi.ARLEN_S;
            cnt_q   <= '0;
            state_q <= R_REQ;
          end else if (axi.AWVALID_S) begin
            id_q    <= axi.AWID_S;
            addr_q  <= axi.AWADDR_S[SRAM_AW+1:2];
            len_q   <= axi.AWLEN_S;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= W_DATA;
          end
        end

        R_REQ: state_q <= R_WAIT;

        R_WAIT: begin
          rdata_q <= DO;
          state_q <= R_DATA;
        end

        R_DATA: begin
          if (axi.RREADY_S) begin
            if (last_beat) begin
              state_q <= IDLE;
            end else begin
              addr_q  <= addr_q + SRAM_AW'(1);
              cnt_q   <= cnt_q + LEN_WIDTH'(1);
              state_q <= R_REQ;
            end
          end
        end

        W_DATA: begin
          if (axi.WVALID_S) begin
            if (w_err) err_q <= 1'b1;
            if (last_beat) begin
              bresp_q <= (err_q || w_err) ? RESP_SLVERR : RESP_OKAY;
              state_q <= B_RESP;
            end else begin
              addr_q <= addr_q + SRAM_AW'(1);
              cnt_q  <= cnt_q + LEN_WIDTH'(1);
            end
          end
        end

        B_RESP: begin
          if (axi.BREADY_S) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: a behavioural SRAM macro, a reference
// memory image and read/write-response scoreboard queues.
module tb_axi_sram_slave;
  import axi_sram_pkg::*;

  logic        ACLK = 1'b0;
  logic        rst;
  logic        CEB, WEB;
  logic [31:0] BWEB, DI, DO;
  logic [13:0] A;

  always #5 ACLK = ~ACLK;

  axi_sram_slave_if bus ();

  axi_sram_slave dut (
    .ACLK (ACLK),
    .rst  (rst),
    .axi  (bus),
    .CEB  (CEB),
    .WEB  (WEB),
    .BWEB (BWEB),
    .A    (A),
    .DI   (DI),
    .DO   (DO)
  );

  // Behavioural SRAM macro with a backdoor port for preloading.
  logic [31:0] sram [0:16383];
  logic        bd_we = 1'b0;
  logic [13:0] bd_addr;
  logic [31:0] bd_data;

  always @(posedge ACLK) begin
    if (bd_we) sram[bd_addr] <= bd_data;
    else if (!CEB) begin
      if (!WEB) sram[A] <= (sram[A] & BWEB) | (DI & ~BWEB);
      else      DO <= sram[A];
    end
  end

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  id;
    logic        last;
  } rbeat_t;

  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
  } bexp_t;

  logic [31:0] ref_mem [0:16383];
  rbeat_t      rd_q[$];
  bexp_t       b_q[$];
  logic [31:0] wbuf   [0:15];
  logic [13:0] beat_a [0:15];
  logic [31:0] beat_bweb [0:15];
  logic        beat_ceb [0:15];
  logic        beat_web [0:15];

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    tick();
    bd_we      = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic ar_issue(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
    logic [13:0] wa;
    int n;
    wa = addr[15:2];
    for (int i = 0; i <= int'(len); i++) begin
      rd_q.push_back(rbeat_t'{data: ref_mem[wa], id: id, last: (i == int'(len))});
      wa = wa + 14'd1;
    end
    bus.ARID_S    = id;
    bus.ARADDR_S  = addr;
    bus.ARLEN_S   = len;
    bus.ARSIZE_S  = 3'd2;
    bus.ARBURST_S = 2'b01;
    bus.ARVALID_S = 1'b1;
    #1;
    n = 0;
    while (!bus.ARREADY_S && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (bus.ARREADY_S !== 1'b1) begin
      errors++;
      $display("FAIL ar_handshake: ARREADY_S=%b, required 1 within 50 cycles", bus.ARREADY_S);
    end
    tick();
    bus.ARVALID_S = 1'b0;
  endtask

  // Collects up to max_beats read beats; stall holds RREADY_S low on the first one.
  task automatic r_collect(input int stall, input int max_beats);
    rbeat_t exp;
    int n;
    logic [31:0] snap_data;
    logic        snap_last;
    logic [7:0]  snap_id;
    for (int b = 0; b < max_beats && rd_q.size() > 0; b++) begin
      bus.RREADY_S = (stall > 0 && b == 0) ? 1'b0 : 1'b1;
      n = 1;
      while (!bus.RVALID_S && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (!bus.RVALID_S || n != 3) begin
        errors++;
        $display("FAIL r_latency beat %0d: RVALID_S=%b after %0d cycles, required 1 after 3", b, bus.RVALID_S, n);
        if (!bus.RVALID_S) begin
          rd_q.delete();
          bus.RREADY_S = 1'b1;
          return;
        end
      end
      exp = rd_q.pop_front();
      if (stall > 0 && b == 0) begin
        snap_data = bus.RDATA_S;
        snap_last = bus.RLAST_S;
        snap_id   = bus.RID_S;
        for (int s = 0; s < stall; s++) begin
          tick();
          checks++;
          if ({bus.RVALID_S, bus.RDATA_S, bus.RLAST_S, bus.RID_S} !== {1'b1, snap_data, snap_last, snap_id}) begin
            errors++;
            $display("FAIL r_stable cycle %0d: valid=%b data=%h last=%b id=%h, required 1 %h %b %h",
                     s, bus.RVALID_S, bus.RDATA_S, bus.RLAST_S, bus.RID_S, snap_data, snap_last, snap_id);
          end
        end
        bus.RREADY_S = 1'b1;
      end
      checks++;
      if (bus.RDATA_S !== exp.data) begin
        errors++;
        $display("FAIL r_data beat %0d: got %h, required %h", b, bus.RDATA_S, exp.data);
      end
      checks++;
      if (bus.RID_S !== exp.id) begin
        errors++;
        $display("FAIL r_id beat %0d: got %h, required %h", b, bus.RID_S, exp.id);
      end
      checks++;
      if (bus.RLAST_S !== exp.last) begin
        errors++;
        $display("FAIL r_last beat %0d: got %b, required %b", b, bus.RLAST_S, exp.last);
      end
      checks++;
      if (bus.RRESP_S !== RESP_OKAY) begin
        errors++;
        $display("FAIL r_resp beat %0d: got %b, required 00", b, bus.RRESP_S);
      end
      tick();
    end
  endtask

  task automatic aw_issue(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
    int n;
    bus.AWID_S    = id;
    bus.AWADDR_S  = addr;
    bus.AWLEN_S   = len;
    bus.AWSIZE_S  = 3'd2;
    bus.AWBURST_S = 2'b01;
    bus.AWVALID_S = 1'b1;
    #1;
    n = 0;
    while (!bus.AWREADY_S && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (bus.AWREADY_S !== 1'b1) begin
      errors++;
      $display("FAIL aw_handshake: AWREADY_S=%b, required 1 within 50 cycles", bus.AWREADY_S);
    end
    tick();
    bus.AWVALID_S = 1'b0;
  endtask

  task automatic w_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [3:0] strb, input int wlast_at);
    logic [13:0] wa;
    logic [31:0] mask;
    int n;
    b_q.push_back(bexp_t'{id: id, resp: (wlast_at != int'(len)) ? 2'b10 : 2'b00});
    wa = addr[15:2];
    for (int k = 0; k < 4; k++) mask[8*k +: 8] = {8{strb[k]}};
    for (int i = 0; i <= int'(len); i++) begin
      bus.WDATA_S  = wbuf[i];
      bus.WSTRB_S  = strb;
      bus.WLAST_S  = (i == wlast_at);
      bus.WVALID_S = 1'b1;
      #1;
      n = 0;
      while (!bus.WREADY_S && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (bus.WREADY_S !== 1'b1) begin
        errors++;
        $display("FAIL w_ready beat %0d: WREADY_S=%b, required 1", i, bus.WREADY_S);
        bus.WVALID_S = 1'b0;
        return;
      end
      beat_a[i]    = A;
      beat_bweb[i] = BWEB;
      beat_ceb[i]  = CEB;
      beat_web[i]  = WEB;
      ref_mem[wa]  = (ref_mem[wa] & ~mask) | (wbuf[i] & mask);
      wa = wa + 14'd1;
      tick();
    end
    bus.WVALID_S = 1'b0;
    bus.WLAST_S  = 1'b0;
  endtask

  task automatic b_collect();
    bexp_t exp;
    int n;
    bus.BREADY_S = 1'b1;
    n = 0;
    while (!bus.BVALID_S && n < 20) begin
      tick();
      n++;
    end
    exp = b_q.pop_front();
    checks++;
    if (bus.BVALID_S !== 1'b1) begin
      errors++;
      $display("FAIL b_valid: BVALID_S=%b, required 1 within 20 cycles", bus.BVALID_S);
      return;
    end
    checks++;
    if ({bus.BID_S, bus.BRESP_S} !== {exp.id, exp.resp}) begin
      errors++;
      $display("FAIL b_resp: id=%h resp=%b, required id=%h resp=%b", bus.BID_S, bus.BRESP_S, exp.id, exp.resp);
    end
    tick();
  endtask

  task automatic write_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [3:0] strb, input int wlast_at);
    aw_issue(id, addr, len);
    w_send(id, addr, len, strb, wlast_at);
    b_collect();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.ARREADY_S, bus.AWREADY_S, bus.WREADY_S, bus.RVALID_S, bus.BVALID_S} !== 5'b0) begin
      errors++;
      $display("FAIL reset_handshake: ar/aw/w/r/b=%b%b%b%b%b, required 00000",
               bus.ARREADY_S, bus.AWREADY_S, bus.WREADY_S, bus.RVALID_S, bus.BVALID_S);
    end
    checks++;
    if ({CEB, WEB, BWEB} !== {1'b1, 1'b1, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL reset_sram: CEB=%b WEB=%b BWEB=%h, required 1 1 ffffffff", CEB, WEB, BWEB);
    end
    checks++;
    if ({bus.RDATA_S, bus.BRESP_S, bus.RRESP_S} !== {32'h0, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL reset_data: RDATA_S=%h BRESP_S=%b RRESP_S=%b, required 0 00 00",
               bus.RDATA_S, bus.BRESP_S, bus.RRESP_S);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.ARREADY_S, bus.AWREADY_S} !== 2'b11) begin
      errors++;
      $display("FAIL idle_ready: ARREADY_S=%b AWREADY_S=%b, required 1 1", bus.ARREADY_S, bus.AWREADY_S);
    end
  endtask

  task automatic test_single_read();
    preload(14'd5, 32'hDEAD_BEEF);
    ar_issue(8'h13, 32'h0000_0014, 4'd0);
    r_collect(0, 16);
  endtask

  task automatic test_burst_write_read();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    write_burst(8'h21, 32'h0000_0100, 4'd3, 4'hF, 3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({beat_ceb[i], beat_web[i], beat_a[i]} !== {1'b0, 1'b0, 14'(14'h40 + i)}) begin
        errors++;
        $display("FAIL w_beat_ctrl %0d: CEB=%b WEB=%b A=%h, required 0 0 %h",
                 i, beat_ceb[i], beat_web[i], beat_a[i], 14'h40 + i);
      end
      checks++;
      if (sram[14'h40 + i] !== 32'(i + 1)) begin
        errors++;
        $display("FAIL sram_word %h: got %h, required %h", 14'h40 + i, sram[14'h40 + i], i + 1);
      end
    end
    ar_issue(8'h22, 32'h0000_0100, 4'd3);
    r_collect(0, 16);
  endtask

  task automatic test_byte_strobe();
    preload(14'h80, 32'h1111_1111);
    wbuf[0] = 32'hAABB_CCDD;
    write_burst(8'h31, 32'h0000_0200, 4'd0, 4'b0101, 0);
    checks++;
    if (beat_bweb[0] !== 32'hFF00_FF00) begin
      errors++;
      $display("FAIL strobe_bweb: got %h, required ff00ff00", beat_bweb[0]);
    end
    checks++;
    if (sram[14'h80] !== 32'h11BB_11DD) begin
      errors++;
      $display("FAIL strobe_word: got %h, required 11bb11dd", sram[14'h80]);
    end
    ar_issue(8'h32, 32'h0000_0200, 4'd0);
    r_collect(0, 16);
  endtask

  task automatic test_simultaneous();
    wbuf[0] = 32'hCAFE_F00D;
    bus.AWID_S    = 8'h41;
    bus.AWADDR_S  = 32'h0000_0300;
    bus.AWLEN_S   = 4'd0;
    bus.AWVALID_S = 1'b1;
    bus.ARVALID_S = 1'b1;
    #1;
    checks++;
    if ({bus.ARREADY_S, bus.AWREADY_S} !== 2'b10) begin
      errors++;
      $display("FAIL ar_priority: ARREADY_S=%b AWREADY_S=%b, required 1 0", bus.ARREADY_S, bus.AWREADY_S);
    end
    ar_issue(8'h42, 32'h0000_0014, 4'd0);
    r_collect(0, 16);
    checks++;
    if (bus.AWREADY_S !== 1'b1) begin
      errors++;
      $display("FAIL aw_after_read: AWREADY_S=%b, required 1", bus.AWREADY_S);
    end
    aw_issue(8'h41, 32'h0000_0300, 4'd0);
    w_send(8'h41, 32'h0000_0300, 4'd0, 4'hF, 0);
    b_collect();
    checks++;
    if (sram[14'hC0] !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL deferred_write: got %h, required cafef00d", sram[14'hC0]);
    end
  endtask

  task automatic test_backpressure();
    preload(14'h90, 32'h1234_5678);
    preload(14'h91, 32'h9ABC_DEF0);
    ar_issue(8'h51, 32'h0000_0240, 4'd1);
    r_collect(5, 16);
  endtask

  task automatic test_wlast_error();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hE000_0000 + 32'(i);
    write_burst(8'h61, 32'h0000_0400, 4'd3, 4'hF, 1);
    wbuf[0] = 32'h5A5A_5A5A;
    write_burst(8'h62, 32'h0000_0500, 4'd0, 4'hF, 0);
  endtask

  task automatic test_wrap();
    wbuf[0] = 32'h0BAD_CAFE;
    wbuf[1] = 32'h600D_D00D;
    write_burst(8'h71, 32'h0000_FFFC, 4'd1, 4'hF, 1);
    checks++;
    if ({beat_a[0], beat_a[1]} !== {14'h3FFF, 14'h0000}) begin
      errors++;
      $display("FAIL wrap_addr: beats at %h %h, required 3fff 0000", beat_a[0], beat_a[1]);
    end
    ar_issue(8'h72, 32'h0000_FFFC, 4'd1);
    r_collect(0, 16);
  endtask

  task automatic test_reset_mid_burst();
    int n;
    for (int i = 0; i < 4; i++) preload(14'(14'hA0 + i), 32'hC0DE_0000 + 32'(i));
    ar_issue(8'h81, 32'h0000_0280, 4'd3);
    r_collect(0, 1);
    bus.RREADY_S = 1'b0;
    n = 0;
    while (!bus.RVALID_S && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.RVALID_S !== 1'b1) begin
      errors++;
      $display("FAIL mid_burst_beat2: RVALID_S=%b, required 1", bus.RVALID_S);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.RVALID_S, CEB, bus.ARREADY_S} !== 3'b011) begin
      errors++;
      $display("FAIL post_reset: RVALID_S=%b CEB=%b ARREADY_S=%b, required 0 1 1",
               bus.RVALID_S, CEB, bus.ARREADY_S);
    end
    rd_q.delete();
    bus.RREADY_S = 1'b1;
    ar_issue(8'h82, 32'h0000_0014, 4'd0);
    r_collect(0, 16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion before 200000 ns");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16384; i++) ref_mem[i] = 32'h0;
    rst           = 1'b1;
    bus.AWID_S    = '0;
    bus.AWADDR_S  = '0;
    bus.AWLEN_S   = '0;
    bus.AWSIZE_S  = 3'd2;
    bus.AWBURST_S = 2'b01;
    bus.AWVALID_S = 1'b0;
    bus.WDATA_S   = '0;
    bus.WSTRB_S   = '0;
    bus.WLAST_S   = 1'b0;
    bus.WVALID_S  = 1'b0;
    bus.BREADY_S  = 1'b1;
    bus.ARID_S    = '0;
    bus.ARADDR_S  = '0;
    bus.ARLEN_S   = '0;
    bus.ARSIZE_S  = 3'd2;
    bus.ARBURST_S = 2'b01;
    bus.ARVALID_S = 1'b0;
    bus.RREADY_S  = 1'b1;

    test_reset();
    test_single_read();
    test_burst_write_read();
    test_byte_strobe();
    test_simultaneous();
    test_backpressure();
    test_wlast_error();
    test_wrap();
    test_reset_mid_burst();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 responder at the slave end of the bus that CPU_wrapper masters drive.
- Accepts AXI read and write bursts and converts them into accesses on a single-port synchronous SRAM macro (IM/DM style).
- Handles one transaction at a time; reads take priority over writes.
- Instantiated once per memory in the system top, behind the bridge, which supplies the 8-bit extended slave-side IDs.

Parameters:
ID_WIDTH, 8, slave-side ID width (master ID plus bridge master tag)
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI and SRAM data width; only 4-byte beats are supported
LEN_WIDTH, 4, AXI burst length width
SRAM_AW, 14, SRAM word-address width (16384 words, 64 KiB)

Ports:
ACLK  in  1  clock
rst  in  1  synchronous active-high reset
AWID_S/AWADDR_S/AWLEN_S/AWSIZE_S/AWBURST_S  in  ID/ADDR/LEN/3/2  write-address payload
AWVALID_S in 1, AWREADY_S out 1  write-address handshake
WDATA_S in 32, WSTRB_S in 4, WLAST_S in 1, WVALID_S in 1, WREADY_S out 1  write data
BID_S out ID, BRESP_S out 2, BVALID_S out 1, BREADY_S in 1  write response
ARID_S/ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S  in  ID/ADDR/LEN/3/2  read-address payload
ARVALID_S in 1, ARREADY_S out 1  read-address handshake
RID_S out ID, RDATA_S out 32, RRESP_S out 2, RLAST_S out 1, RVALID_S out 1, RREADY_S in 1  read data
CEB  out  1  SRAM chip enable, active-low
WEB  out  1  SRAM write enable, active-low (0 = write)
BWEB  out  32  SRAM per-bit write enable, active-low
A  out  SRAM_AW  SRAM word address
DI  out  32  SRAM write data
DO  in  32  SRAM read data, valid the cycle after a read request

Behaviour:
- Reset (sync, rst=1): state IDLE; all VALID/READY outputs 0; CEB=1, WEB=1, BWEB all 1s; RDATA_S=0; BRESP_S=0; RRESP_S=0; beat counter and error flag cleared. Reset mid-burst abandons the burst; there is no partial response.
- States: IDLE, R_REQ, R_WAIT, R_DATA, W_DATA, B_RESP.
- IDLE:
  - ARREADY_S=1.
  - AWREADY_S = !ARVALID_S, so reads win on simultaneous AR/AW.
  - AR handshake: latch ID, word address = ARADDR_S[SRAM_AW+1:2], len, cnt=0; go to R_REQ.
  - AW handshake: latch the same fields from AW, err=0; go to W_DATA.
- R_REQ: CEB=0, WEB=1, A=addr; go to R_WAIT.
- R_WAIT: capture DO into the rdata register at the end of the cycle; go to R_DATA.
- R_DATA:
  - RVALID_S=1, RDATA_S=rdata register, RID_S=latched ID, RRESP_S=OKAY, RLAST_S=(cnt==len).
  - Payload stays stable while RREADY_S=0.
  - On handshake: if cnt==len go to IDLE; else addr+1, cnt+1, go to R_REQ.
  - Latency: AR handshake at cycle T gives RVALID_S at T+3. Each following beat is 3 cycles after the previous beat's handshake.
- W_DATA:
  - WREADY_S=1.
  - On WVALID_S: CEB=0, WEB=0, A=addr, DI=WDATA_S, BWEB byte k = all 0s if WSTRB_S[k] else all 1s.
  - If WLAST_S != (cnt==len), set err.
  - If cnt==len go to B_RESP; else addr+1, cnt+1.
- B_RESP: BVALID_S=1, BID_S=latched ID, BRESP_S = err ? SLVERR(2'b10) : OKAY(2'b00). Hold until BREADY_S, then go to IDLE.
- CEB=1 whenever the block is not in R_REQ or performing a W_DATA beat.
- Address arithmetic: the word address increments modulo 2^SRAM_AW; 0x3FFF+1 wraps to 0. Upper address bits and addr[1:0] are ignored.
- Unsupported fields: all bursts are treated as INCR regardless of AxBURST; AxSIZE is ignored (word only). Neither generates an error.
- Outputs are driven from state and registers only; there is no combinational path from VALID to READY except AWREADY_S's dependence on ARVALID_S.

Decomposition:
- Package axi_sram_pkg holds:
  - state enum
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - default width constants
  - strb-to-BWEB expansion function
- No sub-module is needed: one FSM plus datapath registers.

Test Plan:
- Single read: SRAM[5]=0xDEADBEEF preloaded; AR addr 0x14, len 0, id 0x13 -> RVALID_S at T+3, RDATA_S 0xDEADBEEF, RID_S 0x13, RLAST_S 1, RRESP_S 00.
- Burst write then read-back: AW addr 0x100, len 3, WDATA 1..4, WSTRB F -> BRESP_S 00; SRAM words 0x40..0x43 = 1..4; AR len 3 returns 1,2,3,4 with RLAST_S only on beat 4.
- Byte strobe: write 0xAABBCCDD with WSTRB 4'b0101 over 0x11111111 -> BWEB=0xFF00FF00; word becomes 0x11BB11DD.
- Simultaneous ARVALID_S/AWVALID_S in IDLE -> AR handshake first, AWREADY_S=0 that cycle; write accepted after the read completes.
- Backpressure and errors: RREADY_S low for 5 cycles -> RDATA_S/RLAST_S stable; WLAST_S on beat 2 of len 3 -> BRESP_S 10. Burst at 0xFFFC, len 1 -> second beat at A=0.
- Reset mid read burst, beat 2 of 4 -> next cycle RVALID_S=0, CEB=1, ARREADY_S=1; a new read completes normally.
